mem_sram_ctrl: RTL and testbench

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

---
 rtl/mem_sram_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: splits n-bit loads/stores into two 16-bit SRAM half-accesses with fixed wait states.
// Define MEM_LAST_READ_EN to add a one-entry last-read buffer that answers repeated loads without SRAM.
module mem_sram_ctrl #(
  parameter int n           = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_r_en,
  input  logic         mem_w_en,
  input  logic [n-1:0] alu_res,
  input  logic [n-1:0] st_val,
  output logic         ready,
  output logic [n-1:0] data_mem,
  output logic [17:0]  sram_addr,
  output logic [15:0]  sram_dq_o,
  input  logic [15:0]  sram_dq_i,
  output logic         sram_dq_oe,
  output logic         sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [16:0]  wa_q, wa_d, waIn;
  logic         wr_q, wr_d;
  logic [31:0]  st_q, st_d;
  logic [15:0]  loBuf_q;
  logic [n-1:0] dataMem_q;
  logic [17:0]  addr_q, addr_d;
  logic [15:0]  dqO_q, dqO_d;
  logic         oe_q, oe_d;
  logic         weN_q, weN_d;
  logic         req, hit, accept, busyD, lastLo, lastHi;
  logic         unusedAddr;

  assign req = mem_r_en | mem_w_en;

  // (alu_res - 1024) >> 2: 1024 has zero low bits, so the subtraction never borrows into bit 2
  assign waIn       = alu_res[18:2] - 17'd256;
  assign unusedAddr = ^{alu_res[n-1:19], alu_res[1:0]};

  assign accept = (state_q == IDLE) && req && !hit;
  assign lastLo = (state_q == LO) && (cnt_q == 4'd0);
  assign lastHi = (state_q == HI) && (cnt_q == 4'd0);

`ifdef MEM_LAST_READ_EN
  logic        lrValid_q;
  logic [16:0] lrTag_q;

  assign hit = (state_q == IDLE) && mem_r_en && !mem_w_en && lrValid_q && (lrTag_q == waIn);

  // data_mem already holds the tagged word, so only the tag and valid bit are stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lrValid_q <= 1'b0;
      lrTag_q   <= '0;
    end else if (lastHi && !wr_q) begin
      lrValid_q <= 1'b1;
      lrTag_q   <= wa_q;
    end else if ((state_q == IDLE) && mem_w_en && (lrTag_q == waIn)) begin
      lrValid_q <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wr_d    = wr_q;
    st_d    = st_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LO;
          cnt_d   = CntLoad;
          wa_d    = waIn;
          wr_d    = mem_w_en;
          st_d    = st_val[31:0];
        end
      end
      LO: begin
        if (cnt_q == 4'd0) begin
          state_d = HI;
          cnt_d   = CntLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HI: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          cnt_d   = CntLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = CntLoad;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered, so they are derived from the state being entered
  always_comb begin
    busyD = (state_d == LO) || (state_d == HI);
    oe_d  = busyD && wr_d;
    weN_d = !(oe_d && (cnt_d != 4'd0));
    addr_d = addr_q;
    dqO_d  = dqO_q;
    if (busyD) begin
      addr_d = {wa_d, (state_d == HI)};
      dqO_d  = (state_d == HI) ? st_d[31:16] : st_d[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wa_q      <= '0;
      wr_q      <= 1'b0;
      st_q      <= '0;
      loBuf_q   <= '0;
      dataMem_q <= '0;
      addr_q    <= '0;
      dqO_q     <= '0;
      oe_q      <= 1'b0;
      weN_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wr_q    <= wr_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      dqO_q   <= dqO_d;
      oe_q    <= oe_d;
      weN_q   <= weN_d;
      if (lastLo && !wr_q) loBuf_q <= sram_dq_i;
      if (lastHi && !wr_q) dataMem_q <= n'({sram_dq_i, loBuf_q});
    end
  end

  assign ready      = !rst || (state_q == DONE) || ((state_q == IDLE) && (!req || hit));
  assign data_mem   = dataMem_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dqO_q;
  assign sram_dq_oe = oe_q;
  assign sram_we_n  = weN_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: randomized scoreboard bench for mem_sram_ctrl against a word-level memory model.
// Expected latencies follow MEM_LAST_READ_EN when the macro is defined for the build.
module tb_mem_sram_ctrl;

  localparam int N    = 32;
  localparam int WAIT = 2;
  localparam int LAT  = 2 * WAIT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memREn = 1'b0;
  logic        memWEn = 1'b0;
  logic [31:0] aluRes = '0;
  logic [31:0] stVal = '0;
  logic        ready;
  logic [31:0] dataMem;
  logic [17:0] sramAddr;
  logic [15:0] sramDqO;
  logic [15:0] sramDqI;
  logic        sramDqOe;
  logic        sramWeN;

  mem_sram_ctrl #(.n(N), .WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (memREn),
    .mem_w_en   (memWEn),
    .alu_res    (aluRes),
    .st_val     (stVal),
    .ready      (ready),
    .data_mem   (dataMem),
    .sram_addr  (sramAddr),
    .sram_dq_o  (sramDqO),
    .sram_dq_i  (sramDqI),
    .sram_dq_oe (sramDqOe),
    .sram_we_n  (sramWeN)
  );

  always #5 clk = ~clk;

  logic [15:0] sramArr [0:262143];
  assign sramDqI = sramArr[sramAddr];

  // SRAM model: image initialised once, then written on every clock with WE# low
  initial begin
    for (int i = 0; i < 64; i++) sramArr[i] = 16'($urandom);
    sramArr[2] = 16'h5678;
    sramArr[3] = 16'h1234;
    forever begin
      @(posedge clk);
      if (rst && sramDqOe && !sramWeN) sramArr[sramAddr] = sramDqO;
    end
  end

  typedef struct {
    logic        isWrite;
    logic [16:0] wa;
    logic [31:0] data;
    logic [31:0] wdata;
    int          latency;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] refMem [0:131071];
  logic [31:0] lastRead;
  logic        lrValid;
  logic [16:0] lrTag;
  int          testsRun = 0;
  int          testsFailed = 0;

  function automatic logic [16:0] wordAddr(input logic [31:0] a);
    logic [31:0] t;
    t = (a - 32'd1024) >> 2;
    return t[16:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // reference model update happens at issue time; the monitor checks at completion
  task automatic applyStimulus(input logic rEn, input logic wEn, input logic [31:0] addr,
                               input logic [31:0] data);
    exp_t e;
    e.wa      = wordAddr(addr);
    e.isWrite = wEn;
    e.wdata   = data;
    e.latency = LAT;
    if (wEn) begin
      refMem[e.wa] = data;
      if (lrValid && lrTag == e.wa) lrValid = 1'b0;
      e.data = lastRead;
    end else begin
      e.data = refMem[e.wa];
`ifdef MEM_LAST_READ_EN
      if (lrValid && lrTag == e.wa) e.latency = 0;
`endif
      lrValid  = 1'b1;
      lrTag    = e.wa;
      lastRead = refMem[e.wa];
    end
    expQ.push_back(e);
    @(posedge clk); #1;
    memREn = rEn;
    memWEn = wEn;
    aluRes = addr;
    stVal  = data;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (ready) break;
      @(posedge clk); #1;
      memREn = 1'b0;
      memWEn = 1'b0;
      aluRes = $urandom;
      stVal  = $urandom;
    end
    @(posedge clk); #1;
    memREn = 1'b0;
    memWEn = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic resetMidAccess();
    @(posedge clk); #1;
    memWEn = 1'b1;
    aluRes = 32'd1044;
    stVal  = 32'h0BADF00D;
    @(posedge clk); #1;
    memWEn = 1'b0;
    repeat (WAIT) @(posedge clk);
    #1;
    checkOutput("hi_we_n_before_reset", 32'(sramWeN), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_we_n", 32'(sramWeN), 32'd1);
    checkOutput("reset_oe", 32'(sramDqOe), 32'd0);
    @(posedge clk); #1;
    rst      = 1'b1;
    lastRead = '0;
    lrValid  = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(ready), 32'd1);
    checkOutput("post_reset_data_mem", dataMem, 32'd0);
  endtask

  // monitor: times each request to its ready and pops the matching expectation
  int busy = 0;
  int cnt = 0;
  int weLow = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 0;
      end else begin
        if (busy == 0 && (memREn || memWEn)) begin
          busy  = 1;
          cnt   = 0;
          weLow = 0;
        end
        if (busy != 0) begin
          if (!sramWeN) weLow++;
          if (ready) begin
            busy = 0;
            checkOutput("queue_size", 32'(expQ.size()), 32'd1);
            if (expQ.size() > 0) begin
              e = expQ.pop_front();
              checkOutput("latency", 32'(cnt), 32'(e.latency));
              checkOutput("data_mem", dataMem, e.data);
              checkOutput("done_oe", 32'(sramDqOe), 32'd0);
              checkOutput("done_we_n", 32'(sramWeN), 32'd1);
              if (e.isWrite) begin
                checkOutput("sram_word", {sramArr[{e.wa, 1'b1}], sramArr[{e.wa, 1'b0}]}, e.wdata);
                checkOutput("we_pulses", 32'(weLow), 32'(2 * (WAIT - 1)));
              end else begin
                checkOutput("we_pulses", 32'(weLow), 32'd0);
              end
            end
          end else begin
            cnt++;
            if (cnt > 60) begin
              checkOutput("ready_timeout", 32'(cnt), 32'(LAT));
              busy = 0;
              if (expQ.size() > 0) void'(expQ.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    int          op;
    lastRead = '0;
    lrValid  = 1'b0;
    lrTag    = '0;
    #1;
    for (int i = 0; i < 32; i++) refMem[i] = {sramArr[2 * i + 1], sramArr[2 * i]};

    repeat (2) @(negedge clk);
    memREn = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_data_mem", dataMem, 32'd0);
    checkOutput("rst_we_n", 32'(sramWeN), 32'd1);
    checkOutput("rst_oe", 32'(sramDqOe), 32'd0);
    checkOutput("rst_addr", 32'(sramAddr), 32'd0);
    checkOutput("rst_dq_o", 32'(sramDqO), 32'd0);
    memREn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 32'(ready), 32'd1);

    applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    checkOutput("lo_half_at_0", 32'(sramArr[0]), 32'h0000BEEF);
    checkOutput("hi_half_at_1", 32'(sramArr[1]), 32'h0000DEAD);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'h13579BDF);
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1024 + (32'd1 << 19) + 32'd13, 32'h0);

    resetMidAccess();
    applyStimulus(1'b0, 1'b1, 32'd1044, 32'h0F0F1234);
    applyStimulus(1'b1, 1'b0, 32'd1044, 32'h0);

    for (int k = 0; k < 60; k++) begin
      op   = $urandom_range(0, 3);
      addr = 32'd1024 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      case (op)
        0, 1:    applyStimulus(1'b1, 1'b0, addr, $urandom);
        2:       applyStimulus(1'b0, 1'b1, addr, $urandom);
        default: applyStimulus(1'b1, 1'b1, addr, $urandom);
      endcase
    end

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
